// File: rtl/psram_read_packer.sv
// psram_read_packer
// Packs the PSRAM read byte stream into 16-bit words and writes them to SPRAM
// at sequential addresses from a per-block base. A small word FIFO absorbs
// SPRAM backpressure. The byte source cannot stall, so a word that arrives
// while the FIFO is full (and nothing leaves that cycle) is dropped and
// flagged in a sticky overflow bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; incoming bytes ignored
// S_COLLECT | accepting bytes, pairing them into words, pushing to FIFO
// S_DRAIN   | all block bytes received; emptying FIFO into SPRAM
// S_DONE    | one-cycle completion pulse, then back to idle
module psram_read_packer #(
  parameter int BYTE_WIDTH          = 8,
  parameter int WORD_WIDTH          = 16,
  parameter int SPRAM_ADDRESS_WIDTH = 16,
  parameter int BLOCK_BYTES         = 1024,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 start,
  input  logic [SPRAM_ADDRESS_WIDTH-1:0]       base_addr,
  input  logic [BYTE_WIDTH-1:0]                in_byte_tdata,
  input  logic                                 in_byte_tvalid,
  output logic [WORD_WIDTH-1:0]                spram_wr_tdata,
  output logic [SPRAM_ADDRESS_WIDTH-1:0]       spram_wr_taddress,
  output logic                                 spram_wr_tvalid,
  input  logic                                 spram_wr_tready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [$clog2(BLOCK_BYTES):0]         bytes_received
);

  localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE_IDX = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;

  logic [WORD_WIDTH-1:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W:0]                 r_wr_ptr;
  logic [PTR_W:0]                 r_rd_ptr;

  logic [BYTE_WIDTH-1:0]          r_hold;
  logic                           r_half;
  logic [CNT_W-1:0]               r_byte_cnt;
  logic [SPRAM_ADDRESS_WIDTH-1:0] r_addr;
  logic                           r_overflow;

  logic                           w_empty;
  logic                           w_full;
  logic                           w_start_acc;
  logic                           w_byte_acc;
  logic                           w_last_byte;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_push_ok;
  logic                           w_drop;
  logic [WORD_WIDTH-1:0]          w_word;
  logic                           w_busy;
  logic                           w_done;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_byte_acc  = (r_state == S_COLLECT) && in_byte_tvalid;
  assign w_last_byte = w_byte_acc && (r_byte_cnt == LAST_BYTE_IDX);

  // A word completes on the second byte of each pair; the first byte sits in
  // r_hold and lands in the upper half of the word.
  assign w_word      = {r_hold, in_byte_tdata};
  assign w_push      = w_byte_acc && r_half;
  assign w_pop       = !w_empty && spram_wr_tready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        w_busy = 1'b1;
        if (w_last_byte) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_empty) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any block in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // FIFO pointers; reset flushes any buffered words.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only observed through the non-empty gate.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
  end

  // Byte pairing, byte count and sticky overflow for the current block.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold     <= '0;
      r_half     <= 1'b0;
      r_byte_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_acc) begin
      r_half     <= 1'b0;
      r_byte_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_byte_acc) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
        r_half     <= !r_half;
        if (!r_half) r_hold <= in_byte_tdata;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Write address tracks the FIFO head: loaded from base, advances per pop.
  always_ff @(posedge clk) begin
    if (!resetn)          r_addr <= '0;
    else if (w_start_acc) r_addr <= base_addr;
    else if (w_pop)       r_addr <= r_addr + 1'b1;
  end

  // Head word is gated to zero when empty so stale storage never shows.
  assign spram_wr_tdata    = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign spram_wr_taddress = r_addr;
  assign spram_wr_tvalid   = !w_empty;
  assign busy              = w_busy;
  assign done              = w_done;
  assign overflow          = r_overflow;
  assign bytes_received    = r_byte_cnt;

endmodule

// File: tb/tb_psram_read_packer.sv
// Self-checking bench for psram_read_packer: directed block scenarios plus
// randomized streams, compared cycle by cycle with a queue-based model.
module tb_psram_read_packer;

  localparam int BLOCK = 1024;
  localparam int DEPTH = 8;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  in_byte_tdata;
  logic        in_byte_tvalid;
  logic [15:0] spram_wr_tdata;
  logic [15:0] spram_wr_taddress;
  logic        spram_wr_tvalid;
  logic        spram_wr_tready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [10:0] bytes_received;

  psram_read_packer #(
    .BYTE_WIDTH(8), .WORD_WIDTH(16), .SPRAM_ADDRESS_WIDTH(16),
    .BLOCK_BYTES(BLOCK), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .in_byte_tdata(in_byte_tdata), .in_byte_tvalid(in_byte_tvalid),
    .spram_wr_tdata(spram_wr_tdata), .spram_wr_taddress(spram_wr_taddress),
    .spram_wr_tvalid(spram_wr_tvalid), .spram_wr_tready(spram_wr_tready),
    .busy(busy), .done(done), .overflow(overflow),
    .bytes_received(bytes_received)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase (0 idle, 1 collect, 2 drain, 3 done), word queue.
  int          m_phase;
  logic [15:0] m_q[$];
  logic [15:0] m_addr;
  logic [7:0]  m_hold;
  bit          m_half;
  int          m_cnt;
  bit          m_ovf;

  // Observed DUT activity for the current block.
  int          n_wr;
  int          n_done;
  logic [15:0] wr_addr [4];
  logic [15:0] wr_data [4];
  logic [15:0] last_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit st, input logic [15:0] ba, input bit rn,
                            input bit bv, input logic [7:0] bd, input bit tr);
    bit was_empty, pop, push;
    logic [15:0] w;
    if (!rn) begin
      m_phase = 0; m_q.delete(); m_addr = '0; m_hold = '0;
      m_half = 0; m_cnt = 0; m_ovf = 0;
      return;
    end
    was_empty = (m_q.size() == 0);
    pop  = !was_empty && tr;
    push = 0;
    w    = '0;
    case (m_phase)
      0: if (st) begin
           m_phase = 1; m_addr = ba; m_cnt = 0; m_half = 0; m_ovf = 0;
         end
      1: if (bv) begin
           m_cnt++;
           if (!m_half) begin m_hold = bd; m_half = 1; end
           else begin w = {m_hold, bd}; push = 1; m_half = 0; end
           if (m_cnt == BLOCK) m_phase = 2;
         end
      2: if (was_empty) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (pop) begin
      void'(m_q.pop_front());
      m_addr = m_addr + 16'd1;
    end
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  // One clock cycle: drive, compare against model, then advance the model.
  task automatic step(input bit st, input logic [15:0] ba, input bit rn,
                      input bit bv, input logic [7:0] bd, input bit tr);
    @(negedge clk);
    start = st; base_addr = ba; resetn = rn;
    in_byte_tvalid = bv; in_byte_tdata = bd; spram_wr_tready = tr;
    #1;
    check("tvalid", 32'(spram_wr_tvalid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("tdata", 32'(spram_wr_tdata), 32'(m_q[0]));
    check("taddr", 32'(spram_wr_taddress), 32'(m_addr));
    check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    check("done", 32'(done), 32'(m_phase == 3));
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("bytes", 32'(bytes_received), 32'(m_cnt));
    if (rn && spram_wr_tvalid && tr) begin
      if (n_wr < 4) begin
        wr_addr[n_wr] = spram_wr_taddress;
        wr_data[n_wr] = spram_wr_tdata;
      end
      last_addr = spram_wr_taddress;
      n_wr++;
    end
    if (rn && done) n_done++;
    model_edge(st, ba, rn, bv, bd, tr);
  endtask

  // mode 0: pattern, tready=1 | 1: pattern, tready low first 20 cycles
  // mode 2: full-FIFO push+pop | 3: random | 4: random + mid-block start
  // mode 5: reset after 100 bytes
  task automatic run_block(input logic [15:0] base, input int mode);
    int c, nb, d0;
    bit bv, tr, st, rn;
    logic [7:0] bd;
    logic [15:0] ba;
    n_wr = 0;
    d0 = n_done;
    step(1, base, 1, 0, 8'h00, 0);
    c = 0; nb = 0;
    while (n_done == d0 && c < 6000) begin
      st = 0; ba = base; rn = 1;
      bv = (nb < BLOCK);
      bd = 8'(nb);
      tr = 1;
      case (mode)
        1: tr = (c >= 20);
        2: begin tr = (c >= 17); bd = 8'($urandom); end
        3, 4: begin
          bv = bv && ($urandom_range(0, 3) != 0);
          bd = 8'($urandom);
          tr = $urandom_range(0, 1) == 1;
          st = (m_phase == 3);
          if (mode == 4 && c == 50) begin st = 1; ba = base ^ 16'h5555; end
        end
        5: begin tr = $urandom_range(0, 1) == 1; rn = (nb != 100); end
        default: ;
      endcase
      step(st, ba, rn, bv, bd, tr);
      if (bv) nb++;
      c++;
      if (!rn) break;
    end
    if (mode != 5) check("blk_done_cnt", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    resetn = 0; start = 0; base_addr = '0; in_byte_tvalid = 0;
    in_byte_tdata = '0; spram_wr_tready = 0;
    n_done = 0; n_wr = 0; last_addr = '0;
    repeat (2) @(posedge clk);
    model_edge(0, 16'h0, 0, 0, 8'h0, 0);
    step(0, 16'h0, 0, 0, 8'h0, 0);

    // Reset values
    @(negedge clk); #1;
    check("rst_tvalid", 32'(spram_wr_tvalid), 32'd0);
    check("rst_tdata", 32'(spram_wr_tdata), 32'd0);
    check("rst_taddr", 32'(spram_wr_taddress), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bytes", 32'(bytes_received), 32'd0);
    step(0, 16'h0, 1, 0, 8'h0, 0);

    // Full block, no stall
    run_block(16'h0100, 0);
    check("full_writes", 32'(n_wr), 32'd512);
    check("full_addr0", 32'(wr_addr[0]), 32'h0100);
    check("full_data0", 32'(wr_data[0]), 32'h0001);
    check("full_data1", 32'(wr_data[1]), 32'h0203);
    check("full_last", 32'(last_addr), 32'h02FF);
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_bytes", 32'(bytes_received), 32'd1024);

    // Backpressure overflow: 2 words dropped
    run_block(16'h2000, 1);
    check("bp_writes", 32'(n_wr), 32'd510);
    check("bp_ovf", 32'(overflow), 32'd1);
    repeat (3) step(0, 16'h0, 1, 1, 8'hAA, 1);
    check("bp_ovf_hold", 32'(overflow), 32'd1);

    // Simultaneous push/pop on a full FIFO
    run_block(16'h3000, 2);
    check("pp_writes", 32'(n_wr), 32'd512);
    check("pp_ovf", 32'(overflow), 32'd0);

    // Address wrap
    run_block(16'hFFFE, 3);
    check("wrap_a0", 32'(wr_addr[0]), 32'hFFFE);
    check("wrap_a1", 32'(wr_addr[1]), 32'hFFFF);
    check("wrap_a2", 32'(wr_addr[2]), 32'h0000);
    check("wrap_a3", 32'(wr_addr[3]), 32'h0001);

    // Reset mid-block, then a clean block from base 0
    run_block(16'h4000, 5);
    n_wr = 0;
    @(negedge clk); #1;
    check("mrst_tvalid", 32'(spram_wr_tvalid), 32'd0);
    check("mrst_taddr", 32'(spram_wr_taddress), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_bytes", 32'(bytes_received), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    step(0, 16'h0, 1, 0, 8'h0, 0);
    run_block(16'h0000, 0);
    check("mrst_writes", 32'(n_wr), 32'd512);
    check("mrst_a0", 32'(wr_addr[0]), 32'h0000);

    // Ignored inputs: bytes in idle, start mid-collect
    n_wr = 0;
    for (int i = 0; i < 10; i++) step(0, 16'h0, 1, 1, 8'($urandom), 1);
    check("idle_writes", 32'(n_wr), 32'd0);
    run_block(16'h1234, 4);
    check("ign_a0", 32'(wr_addr[0]), 32'h1234);
    check("ign_last", 32'(last_addr), 32'(16'h1234 + 16'(n_wr - 1)));

    // Further randomized blocks
    for (int k = 0; k < 2; k++) run_block(16'($urandom), 3);
    repeat (4) step(0, 16'h0, 1, 0, 8'h0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psram_read_packer.md
Name: psram_read_packer

Overview:
- Downstream stage of the PSRAM controller's read path. Consumes the byte stream the controller emits while reading a PSRAM block.
- Packs byte pairs into 16-bit words and buffers them in a small FIFO to absorb SPRAM backpressure.
- Writes the words to SPRAM at sequential addresses starting from a per-block base address.
- Reports completion and overflow so the monarch side can sequence the next block.

Parameters:
- BYTE_WIDTH, 8, width of each incoming PSRAM byte.
- WORD_WIDTH, 16, SPRAM word width; must equal 2*BYTE_WIDTH.
- SPRAM_ADDRESS_WIDTH, 16, SPRAM word address width.
- BLOCK_BYTES, 1024, bytes per block; must be even.
- FIFO_DEPTH, 8, word FIFO entries; must be a power of 2.

Ports:
- clk  in  1  single clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a block; honoured only in IDLE.
- base_addr  in  SPRAM_ADDRESS_WIDTH  first SPRAM word address; sampled on an accepted start.
- in_byte_tdata  in  BYTE_WIDTH  byte from the PSRAM controller.
- in_byte_tvalid  in  1  byte strobe. There is no ready: the source cannot stall.
- spram_wr_tdata  out  WORD_WIDTH  FIFO head word.
- spram_wr_taddress  out  SPRAM_ADDRESS_WIDTH  write address of the head word.
- spram_wr_tvalid  out  1  FIFO non-empty.
- spram_wr_tready  in  1  SPRAM accepts the word.
- busy  out  1  high in COLLECT and DRAIN.
- done  out  1  one-cycle pulse at block completion.
- overflow  out  1  sticky; a word was dropped during this block.
- bytes_received  out  $clog2(BLOCK_BYTES)+1  bytes accepted in the current block.

Behaviour:
- Reset (resetn low at a clk edge), required values:
  - state = IDLE; FIFO empty; hold register, half flag, byte counter and address = 0.
  - All outputs 0.
  - Reset mid-block aborts the block immediately: FIFO is flushed and done is not pulsed.
- IDLE:
  - in_byte_tvalid is ignored.
  - start=1: latch base_addr into the write-address register, clear byte counter, half flag and overflow; go to COLLECT next cycle.
- COLLECT, on each in_byte_tvalid cycle:
  - half=0: byte goes to hold register (becomes word[15:8]); half <= 1.
  - half=1: push {hold, in_byte_tdata} into the FIFO (first byte in bits [15:8], second in [7:0]); half <= 0.
  - bytes_received increments on every accepted byte.
  - On the byte that makes bytes_received = BLOCK_BYTES, go to DRAIN next cycle.
- Full FIFO:
  - Push while full with no pop in the same cycle: the word is dropped and overflow <= 1. The byte still counts toward bytes_received.
  - Push and pop in the same cycle when full are both legal: no drop, occupancy unchanged.
- Output side, all states:
  - spram_wr_tvalid = !empty.
  - spram_wr_tdata and spram_wr_taddress present the head word and the current address.
  - On tvalid & tready: pop, and address <= address+1, wrapping modulo 2^SPRAM_ADDRESS_WIDTH.
  - A word pushed at edge N is first visible on the outputs in cycle N+1.
  - tdata and taddress are held stable while tvalid=1 and tready=0.
- DRAIN:
  - in_byte_tvalid is ignored.
  - When the FIFO is empty (including the cycle after the final pop), go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; go to IDLE. A start in this cycle is ignored.
- start asserted while busy or in DONE is ignored; base_addr is not re-sampled.
- overflow holds its value through IDLE and clears only on the next accepted start.

Test Plan:
- Full block, no stall: base_addr=0x0100, 1024 bytes of pattern 0x00,0x01,...,0xFF repeating, one byte per cycle, tready=1 -> 512 writes at 0x0100..0x02FF, first data 0x0001, 0x0203; one done pulse; overflow=0; bytes_received=1024.
- Backpressure overflow: FIFO_DEPTH=8, bytes every cycle, tready=0 for the first 20 cycles of COLLECT -> 10 words pushed, first 8 retained, 2 dropped; overflow=1; total writes 510; done still pulses once.
- Full-FIFO simultaneous push/pop: fill the FIFO to 8 entries, then assert tready on the same cycle as the next push -> no drop, overflow=0, occupancy stays 8, data order preserved.
- Address wrap: base_addr=0xFFFE, 8 bytes (BLOCK_BYTES=8 build) -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-block: resetn low for 1 cycle after 100 bytes -> next cycle all outputs 0, FIFO empty, no done. A new start with base_addr=0x0000 completes normally.
- Ignored inputs: bytes strobed in IDLE, and a start pulse mid-COLLECT with a different base_addr -> no writes from the IDLE bytes; address sequence keeps the original base; exactly one done.
